// File: rtl/issue_lsu_age_if.sv
// rtl/issue_lsu_age_if.sv - dispatch, CDB and issue bundle for the LSU issue queue
// The queue is the slave; dispatch/rename, the CDB and the LSU pipes form the master side.
interface issue_lsu_age_if #(
   parameter int RS_DEPTH   = 8,
   parameter int DATA_W     = 32,
   parameter int TAG_W      = 6,
   parameter int SB_W       = 4,
   parameter int UOP_W      = 8,
   parameter int DISPATCH_W = 4,
   parameter int CDB_W      = 4,
   parameter int ISSUE_W    = 2
);
   localparam int CNT_W = $clog2(RS_DEPTH + 1);

   logic                                  flush_i;
   logic [DISPATCH_W-1:0]                 dispatch_valid;
   logic [DISPATCH_W-1:0][UOP_W-1:0]      dispatch_op;
   logic [DISPATCH_W-1:0]                 dispatch_is_store;
   logic [DISPATCH_W-1:0][TAG_W-1:0]      dispatch_dst;
   logic [DISPATCH_W-1:0][DATA_W-1:0]     dispatch_v1;
   logic [DISPATCH_W-1:0][TAG_W-1:0]      dispatch_q1;
   logic [DISPATCH_W-1:0]                 dispatch_r1;
   logic [DISPATCH_W-1:0][DATA_W-1:0]     dispatch_v2;
   logic [DISPATCH_W-1:0][TAG_W-1:0]      dispatch_q2;
   logic [DISPATCH_W-1:0]                 dispatch_r2;
   logic [DISPATCH_W-1:0][SB_W-1:0]       dispatch_sb_id;
   logic                                  issue_ready;
   logic [CNT_W-1:0]                      free_count_o;
   logic [CDB_W-1:0]                      cdb_valid;
   logic [CDB_W-1:0][TAG_W-1:0]           cdb_tag;
   logic [CDB_W-1:0][DATA_W-1:0]          cdb_val;
   logic [ISSUE_W-1:0]                    fu_ready_i;
   logic [ISSUE_W-1:0]                    lsu_en;
   logic [ISSUE_W-1:0][UOP_W-1:0]         lsu_uop;
   logic [ISSUE_W-1:0][DATA_W-1:0]        lsu_v1;
   logic [ISSUE_W-1:0][DATA_W-1:0]        lsu_v2;
   logic [ISSUE_W-1:0][TAG_W-1:0]         lsu_dst;
   logic [ISSUE_W-1:0][SB_W-1:0]          lsu_sb_id;

   modport master (
      output flush_i, dispatch_valid, dispatch_op, dispatch_is_store, dispatch_dst,
             dispatch_v1, dispatch_q1, dispatch_r1, dispatch_v2, dispatch_q2, dispatch_r2,
             dispatch_sb_id, cdb_valid, cdb_tag, cdb_val, fu_ready_i,
      input  issue_ready, free_count_o, lsu_en, lsu_uop, lsu_v1, lsu_v2, lsu_dst, lsu_sb_id
   );

   modport slave (
      input  flush_i, dispatch_valid, dispatch_op, dispatch_is_store, dispatch_dst,
             dispatch_v1, dispatch_q1, dispatch_r1, dispatch_v2, dispatch_q2, dispatch_r2,
             dispatch_sb_id, cdb_valid, cdb_tag, cdb_val, fu_ready_i,
      output issue_ready, free_count_o, lsu_en, lsu_uop, lsu_v1, lsu_v2, lsu_dst, lsu_sb_id
   );
endinterface

// File: rtl/issue_lsu_age.sv
// rtl/issue_lsu_age.sv - LSU issue queue with CDB wakeup and age-matrix oldest-first select
// older[i][j]=1 means entry i is older than entry j; only bits between busy entries are meaningful.
module issue_lsu_age #(
   parameter int RS_DEPTH      = 8,
   parameter int DATA_W        = 32,
   parameter int TAG_W         = 6,
   parameter int SB_W          = 4,
   parameter int UOP_W         = 8,
   parameter int DISPATCH_W    = 4,
   parameter int CDB_W         = 4,
   parameter int ISSUE_W       = 2,
   parameter int STORE_INORDER = 1
) (
   input logic            clk,
   input logic            rst,
   issue_lsu_age_if.slave bus
);
   localparam int IDX_W  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
   localparam int CNT_W  = $clog2(RS_DEPTH + 1);
   localparam int LANE_W = (DISPATCH_W > 1) ? $clog2(DISPATCH_W) : 1;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] val;
   } wake_t;

   // Lowest matching CDB lane wins, hence the descending scan.
   function automatic wake_t cdb_match(input logic [TAG_W-1:0]            tag,
                                       input logic [CDB_W-1:0]            cv,
                                       input logic [CDB_W-1:0][TAG_W-1:0] ct,
                                       input logic [CDB_W-1:0][DATA_W-1:0] cval);
      wake_t w;
      w = '0;
      for (int k = CDB_W - 1; k >= 0; k--) begin
         if (cv[k] && ct[k] == tag) begin
            w.hit = 1'b1;
            w.val = cval[k];
         end
      end
      return w;
   endfunction

   logic [RS_DEPTH-1:0] busy;
   logic [RS_DEPTH-1:0] is_store;
   logic [RS_DEPTH-1:0] r1;
   logic [RS_DEPTH-1:0] r2;
   logic [UOP_W-1:0]    op    [RS_DEPTH];
   logic [TAG_W-1:0]    dst   [RS_DEPTH];
   logic [DATA_W-1:0]   v1    [RS_DEPTH];
   logic [TAG_W-1:0]    q1    [RS_DEPTH];
   logic [DATA_W-1:0]   v2    [RS_DEPTH];
   logic [TAG_W-1:0]    q2    [RS_DEPTH];
   logic [SB_W-1:0]     sb_id [RS_DEPTH];
   logic [RS_DEPTH-1:0] older [RS_DEPTH];

   logic [CNT_W-1:0]    free_count;
   logic                ready_int;
   logic                do_dispatch;
   logic [RS_DEPTH-1:0] alloc_hit;
   logic [LANE_W-1:0]   alloc_lane [RS_DEPTH];
   wake_t               w1  [RS_DEPTH];
   wake_t               w2  [RS_DEPTH];
   wake_t               lw1 [DISPATCH_W];
   wake_t               lw2 [DISPATCH_W];
   logic [RS_DEPTH-1:0] eligible;
   logic [CNT_W-1:0]    rank [RS_DEPTH];
   logic [ISSUE_W-1:0]  en;
   logic [IDX_W-1:0]    sel [ISSUE_W];
   logic [RS_DEPTH-1:0] issued;

   always_comb begin
      free_count = '0;
      for (int i = 0; i < RS_DEPTH; i++)
         free_count = free_count + CNT_W'(!busy[i]);
   end

   assign ready_int        = (free_count >= CNT_W'(DISPATCH_W));
   assign do_dispatch      = ready_int && !bus.flush_i;
   assign bus.issue_ready  = ready_int;
   assign bus.free_count_o = free_count;

   always_comb begin
      logic [RS_DEPTH-1:0] taken;
      logic                found;
      taken     = '0;
      alloc_hit = '0;
      found     = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++)
         alloc_lane[i] = '0;
      for (int l = 0; l < DISPATCH_W; l++) begin
         found = 1'b0;
         if (do_dispatch && bus.dispatch_valid[l]) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (!found && !busy[i] && !taken[i]) begin
                  found         = 1'b1;
                  taken[i]      = 1'b1;
                  alloc_hit[i]  = 1'b1;
                  alloc_lane[i] = LANE_W'(l);
               end
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         w1[i] = cdb_match(q1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         w2[i] = cdb_match(q2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      end
      for (int l = 0; l < DISPATCH_W; l++) begin
         lw1[l] = cdb_match(bus.dispatch_q1[l], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
         lw2[l] = cdb_match(bus.dispatch_q2[l], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
      end
   end

   // Readiness comes from registered state, so a same-cycle wakeup or write issues next cycle.
   always_comb begin
      logic older_store;
      older_store = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         older_store = 1'b0;
         for (int j = 0; j < RS_DEPTH; j++)
            if (busy[j] && is_store[j] && older[j][i])
               older_store = 1'b1;
         eligible[i] = busy[i] && r1[i] && r2[i] &&
                       !((STORE_INORDER != 0) && is_store[i] && older_store);
      end
   end

   always_comb begin
      for (int i = 0; i < RS_DEPTH; i++) begin
         rank[i] = '0;
         for (int j = 0; j < RS_DEPTH; j++)
            if (eligible[j] && older[j][i])
               rank[i] = rank[i] + CNT_W'(1);
      end
   end

   // Ready ports take successive ranks; stalled ports are skipped without using a slot.
   always_comb begin
      int slot;
      slot   = 0;
      en     = '0;
      issued = '0;
      for (int p = 0; p < ISSUE_W; p++) begin
         sel[p] = '0;
         if (bus.fu_ready_i[p] && !bus.flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
               if (eligible[i] && int'(rank[i]) == slot) begin
                  en[p]     = 1'b1;
                  sel[p]    = IDX_W'(i);
                  issued[i] = 1'b1;
               end
            end
            slot = slot + 1;
         end
      end
   end

   assign bus.lsu_en = en;

   always_comb begin
      for (int p = 0; p < ISSUE_W; p++) begin
         bus.lsu_uop[p]   = en[p] ? op[sel[p]]    : '0;
         bus.lsu_v1[p]    = en[p] ? v1[sel[p]]    : '0;
         bus.lsu_v2[p]    = en[p] ? v2[sel[p]]    : '0;
         bus.lsu_dst[p]   = en[p] ? dst[sel[p]]   : '0;
         bus.lsu_sb_id[p] = en[p] ? sb_id[sel[p]] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= '0;
         is_store <= '0;
         r1       <= '0;
         r2       <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            older[i] <= '0;
            op[i]    <= '0;
            dst[i]   <= '0;
            v1[i]    <= '0;
            q1[i]    <= '0;
            v2[i]    <= '0;
            q2[i]    <= '0;
            sb_id[i] <= '0;
         end
      end else if (bus.flush_i) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (issued[i])
               busy[i] <= 1'b0;
            if (busy[i] && !r1[i] && w1[i].hit) begin
               r1[i] <= 1'b1;
               v1[i] <= w1[i].val;
            end
            if (busy[i] && !r2[i] && w2[i].hit) begin
               r2[i] <= 1'b1;
               v2[i] <= w2[i].val;
            end
            if (alloc_hit[i]) begin
               busy[i]     <= 1'b1;
               is_store[i] <= bus.dispatch_is_store[alloc_lane[i]];
               op[i]       <= bus.dispatch_op[alloc_lane[i]];
               dst[i]      <= bus.dispatch_dst[alloc_lane[i]];
               sb_id[i]    <= bus.dispatch_sb_id[alloc_lane[i]];
               q1[i]       <= bus.dispatch_q1[alloc_lane[i]];
               q2[i]       <= bus.dispatch_q2[alloc_lane[i]];
               r1[i]       <= bus.dispatch_r1[alloc_lane[i]] || lw1[alloc_lane[i]].hit;
               r2[i]       <= bus.dispatch_r2[alloc_lane[i]] || lw2[alloc_lane[i]].hit;
               v1[i]       <= (!bus.dispatch_r1[alloc_lane[i]] && lw1[alloc_lane[i]].hit) ?
                              lw1[alloc_lane[i]].val : bus.dispatch_v1[alloc_lane[i]];
               v2[i]       <= (!bus.dispatch_r2[alloc_lane[i]] && lw2[alloc_lane[i]].hit) ?
                              lw2[alloc_lane[i]].val : bus.dispatch_v2[alloc_lane[i]];
            end
            // New entries are younger than every busy entry; lower lane is older within a group.
            for (int j = 0; j < RS_DEPTH; j++) begin
               if (alloc_hit[i] && alloc_hit[j])
                  older[i][j] <= (alloc_lane[i] < alloc_lane[j]);
               else if (alloc_hit[i])
                  older[i][j] <= 1'b0;
               else if (alloc_hit[j])
                  older[i][j] <= busy[i];
            end
         end
      end
   end
endmodule
